// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the asynchronous SRAM controller.
package sram_ctrl_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int SRAM_ADDR_W = 20;
    localparam int WAIT_W      = 4;
endpackage

// File: rtl/sram_strobe_timer.sv
// Loadable down-counter with zero flag for wait-state strobes; one-cycle load, saturates at zero.
// Latency: zero_o reflects the registered count; no backpressure.
module sram_strobe_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);
    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);
endmodule

// File: rtl/sram_ctrl.sv
// Word-wide async SRAM controller: IDLE accept, RD/WR_WAIT+1 strobe cycles, one DONE cycle.
// Stalls the requester until DONE; optional SRAM_POSTED_WRITE_EN releases writes at accept.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W  = SRAM_ADDR_W,
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [31:0]       address,
    input  logic [31:0]       data_i,
    output logic [31:0]       data_o,
    output logic              stall_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [31:0]       sram_data_o,
    output logic              sram_data_oe_o,
    input  logic [31:0]       sram_data_i,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o
);
    state_e            state_q;
    logic [31:0]       data_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdat_q;
    logic              ce_n_q, oe_n_q, we_n_q, doe_q;
    logic              tmr_zero;
    logic              req;
    logic [WAIT_W-1:0] wait_ld;
    logic              unused_addr;
`ifdef SRAM_POSTED_WRITE_EN
    logic              wr_q;
`endif

    assign req         = read_i | write_i;
    assign wait_ld     = write_i ? WAIT_W'(WR_WAIT) : WAIT_W'(RD_WAIT);
    assign unused_addr = ^{address[31:ADDR_W+2], address[1:0]};

    sram_strobe_timer #(.W(WAIT_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     ((state_q == ST_IDLE) && req),
        .load_val_i (wait_ld),
        .dec_i      ((state_q == ST_READ) || (state_q == ST_WRITE)),
        .zero_o     (tmr_zero)
    );

    // Posted mode: the requester only waits on a write that is still draining.
    always_comb begin
        stall_o = 1'b0;
        case (state_q)
`ifdef SRAM_POSTED_WRITE_EN
            ST_IDLE:  stall_o = write_i ? 1'b0 : read_i;
            ST_READ:  stall_o = 1'b1;
            ST_WRITE: stall_o = req;
            ST_DONE:  stall_o = wr_q & req;
`else
            ST_IDLE:  stall_o = req;
            ST_READ:  stall_o = 1'b1;
            ST_WRITE: stall_o = 1'b1;
            ST_DONE:  stall_o = 1'b0;
`endif
            default:  stall_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            addr_q  <= '0;
            wdat_q  <= '0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            doe_q   <= 1'b0;
`ifdef SRAM_POSTED_WRITE_EN
            wr_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (write_i) begin
                        state_q <= ST_WRITE;
                        addr_q  <= address[ADDR_W+1:2];
                        wdat_q  <= data_i;
                        ce_n_q  <= 1'b0;
                        we_n_q  <= 1'b0;
                        doe_q   <= 1'b1;
`ifdef SRAM_POSTED_WRITE_EN
                        wr_q    <= 1'b1;
`endif
                    end else if (read_i) begin
                        state_q <= ST_READ;
                        addr_q  <= address[ADDR_W+1:2];
                        ce_n_q  <= 1'b0;
                        oe_n_q  <= 1'b0;
`ifdef SRAM_POSTED_WRITE_EN
                        wr_q    <= 1'b0;
`endif
                    end
                end
                ST_READ: begin
                    if (tmr_zero) begin
                        state_q <= ST_DONE;
                        data_q  <= sram_data_i;
                        ce_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    // Release we_n first; ce_n, address and data stay for hold time.
                    if (tmr_zero) begin
                        state_q <= ST_DONE;
                        we_n_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    ce_n_q  <= 1'b1;
                    doe_q   <= 1'b0;
                end
            endcase
        end
    end

    assign data_o         = data_q;
    assign sram_addr_o    = addr_q;
    assign sram_data_o    = wdat_q;
    assign sram_data_oe_o = doe_q;
    assign sram_ce_n_o    = ce_n_q;
    assign sram_oe_n_o    = oe_n_q;
    assign sram_we_n_o    = we_n_q;
endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with an SRAM model and a data_o scoreboard.
module tb_sram_ctrl;
    localparam int ADDR_W  = 20;
    localparam int RD_WAIT = 1;
    localparam int WR_WAIT = 0;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              read_i, write_i;
    logic [31:0]       address, data_i, data_o;
    logic              stall_o;
    logic [ADDR_W-1:0] sram_addr_o;
    logic [31:0]       sram_data_o, sram_data_i;
    logic              sram_data_oe_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] sb[$];
    logic        mon_en = 1'b1;
    logic        mem_clr;
    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    sram_ctrl #(.ADDR_W(ADDR_W), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .read_i         (read_i),
        .write_i        (write_i),
        .address        (address),
        .data_i         (data_i),
        .data_o         (data_o),
        .stall_o        (stall_o),
        .sram_addr_o    (sram_addr_o),
        .sram_data_o    (sram_data_o),
        .sram_data_oe_o (sram_data_oe_o),
        .sram_data_i    (sram_data_i),
        .sram_ce_n_o    (sram_ce_n_o),
        .sram_oe_n_o    (sram_oe_n_o),
        .sram_we_n_o    (sram_we_n_o)
    );

    // SRAM model: word array, read driven while ce_n/oe_n low, write captured on a clock with we_n low.
    assign sram_data_i = (!sram_ce_n_o && !sram_oe_n_o) ? mem[sram_addr_o[7:0]] : 32'h0BAD_0BAD;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[4] <= 32'hDEAD_BEEF;
        end else if (!sram_ce_n_o && !sram_we_n_o && sram_data_oe_o) begin
            mem[sram_addr_o[7:0]] <= sram_data_o;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every completed handshake pops the data_o value expected at that point.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && mon_en && !stall_o && (read_i || write_i)) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_underflow: got completion, expected none");
            end else begin
                check("data_o", data_o, sb.pop_front());
            end
        end
    end

    // Issue one request from posedge+1, hold it until stall_o drops, then release it.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] adr,
                          input logic [31:0] wd, input logic [31:0] exp_dout,
                          output int stall_n, output int oe_cnt, output int we_cnt,
                          output int doe_cnt, output int hold_cnt,
                          output logic [31:0] seen_addr, output logic [31:0] seen_wdat);
        logic done;
        sb.push_back(exp_dout);
        read_i = rd; write_i = wr; address = adr; data_i = wd;
        stall_n = 0; oe_cnt = 0; we_cnt = 0; doe_cnt = 0; hold_cnt = 0;
        seen_addr = 32'hFFFF_FFFF; seen_wdat = 32'hFFFF_FFFF;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (stall_o) stall_n++;
            if (!sram_oe_n_o) oe_cnt++;
            if (!sram_we_n_o) begin we_cnt++; seen_wdat = sram_data_o; end
            if (sram_data_oe_o) doe_cnt++;
            if (sram_data_oe_o && sram_we_n_o && !sram_ce_n_o) hold_cnt++;
            if (!sram_ce_n_o) seen_addr = 32'(sram_addr_o);
            if (!stall_o) done = 1'b1;
            // Once this access is strobing, scramble the inputs: they must be ignored.
            if ((!sram_oe_n_o && rd && !wr) || (!sram_we_n_o && wr)) begin
                address = 32'hFFFF_FFFC;
                data_i  = ~wd;
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL req_timeout: got stall after 40 cycles, expected completion");
        end
        @(posedge clk);
        #1;
        read_i = 1'b0; write_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, oe, we, doe, hold;
        logic [31:0] sa, sw;

        rst_n = 1'b0; mem_clr = 1'b1;
        read_i = 1'b0; write_i = 1'b0; address = '0; data_i = '0;
        repeat (3) @(negedge clk);
        check("rst_data_o",  data_o, 32'h0);
        check("rst_addr",    32'(sram_addr_o), 32'h0);
        check("rst_pins",    {29'h0, sram_ce_n_o, sram_oe_n_o, sram_we_n_o}, 32'h7);
        check("rst_doe",     32'(sram_data_oe_o), 32'h0);
        check("rst_stall",   32'(stall_o), 32'h0);
        mem_clr = 1'b0;
        rst_n   = 1'b1;
        @(posedge clk); #1;

        // Read 0x10 -> word 4
        do_req(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, st, oe, we, doe, hold, sa, sw);
        check("rd_addr",   sa, 32'h4);
        check("rd_oe_cyc", oe, 32'd2);
        check("rd_stall",  st, 32'd3);
        repeat (3) @(negedge clk);
        check("rd_hold", data_o, 32'hDEAD_BEEF);

        // Reset during the write strobe: pins release at once, nothing is written.
        mon_en = 1'b0;
        @(posedge clk); #1;
        write_i = 1'b1; address = 32'h40; data_i = 32'hCAFE_F00D;
        @(negedge clk);
        @(negedge clk);
        check("mid_we_low", 32'(sram_we_n_o), 32'h0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_pins", {30'h0, sram_ce_n_o, sram_we_n_o}, 32'h3);
        check("mid_rst_doe",  32'(sram_data_oe_o), 32'h0);
        check("mid_rst_dout", data_o, 32'h0);
        write_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_idle", 32'(stall_o), 32'h0);
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Write 0x12345678 to 0x20 -> word 8
        do_req(1'b0, 1'b1, 32'h20, 32'h1234_5678, 32'h0, st, oe, we, doe, hold, sa, sw);
`ifdef SRAM_POSTED_WRITE_EN
        check("wr_posted_stall", st, 32'd0);
`else
        check("wr_stall",    st, 32'd2);
        check("wr_we_cyc",   we, 32'd1);
        check("wr_data",     sw, 32'h1234_5678);
        check("wr_addr",     sa, 32'h8);
        check("wr_doe_cyc",  doe, 32'd2);
        check("wr_hold_cyc", hold, 32'd1);
        check("wr_no_oe",    oe, 32'd0);
`endif

        // Read-modify-write of word 8
        do_req(1'b1, 1'b0, 32'h20, 32'h0, 32'h1234_5678, st, oe, we, doe, hold, sa, sw);
        check("rmw_rd_addr", sa, 32'h8);
`ifdef SRAM_POSTED_WRITE_EN
        check("rmw_rd_stall", st, 32'd5);
`else
        check("rmw_rd_stall", st, 32'd3);
`endif
        do_req(1'b0, 1'b1, 32'h20, 32'hAA34_5678, 32'h1234_5678, st, oe, we, doe, hold, sa, sw);

        // Read and write together: write wins
        do_req(1'b1, 1'b1, 32'h30, 32'h55AA_55AA, 32'h1234_5678, st, oe, we, doe, hold, sa, sw);
        check("both_no_oe", oe, 32'd0);
        check("both_stall", st, 32'd2);

        // Read back the address just written
        do_req(1'b1, 1'b0, 32'h30, 32'h0, 32'h55AA_55AA, st, oe, we, doe, hold, sa, sw);
        check("rb_oe_cyc", oe, 32'd2);
        check("rb_addr",   sa, 32'hC);
`ifdef SRAM_POSTED_WRITE_EN
        check("rb_stall", st, 32'd5);
`else
        check("rb_stall", st, 32'd3);
`endif

        repeat (5) @(negedge clk);
        check("mem_rmw",    mem[8],  32'hAA34_5678);
        check("mem_both",   mem[12], 32'h55AA_55AA);
        check("mem_rst_wr", mem[16], 32'h0);
        check("final_hold", data_o,  32'h55AA_55AA);
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Word-wide asynchronous SRAM controller directly downstream of the byte-merge stage.
- Takes that stage's word-granular read/write requests (byte merging already done) and drives the external SRAM pins with programmable wait states.
- Returns registered read data and a stall back to the pipeline.
- Read data stays stable after completion, so the upstream read-modify-write cycle sees old data on the following cycle.

Parameters:
- ADDR_W, 20, SRAM word-address width; uses address[ADDR_W+1:2].
- RD_WAIT, 1, extra read-strobe cycles beyond the first (0..15).
- WR_WAIT, 1, extra write-strobe cycles beyond the first (0..15).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- read_i  in  1  read request
- write_i  in  1  write request
- address  in  32  byte address; bits [1:0] ignored
- data_i  in  32  write data (already byte-merged)
- data_o  out  32  read data, registered, held
- stall_o  out  1  request not yet complete
- sram_addr_o  out  ADDR_W  SRAM word address
- sram_data_o  out  32  SRAM write data
- sram_data_oe_o  out  1  drive enable for bidirectional data pad
- sram_data_i  in  32  SRAM read data
- sram_ce_n_o  out  1  chip enable, active-low
- sram_oe_n_o  out  1  output enable, active-low
- sram_we_n_o  out  1  write enable, active-low

Behaviour:
- Reset (async, any state):
  - state=IDLE; counter=0; data_o=0; sram_addr_o=0; sram_data_o=0.
  - ce_n/oe_n/we_n=1; sram_data_oe_o=0.
  - Any in-flight access is abandoned; no write completes.
- States: IDLE, READ, WRITE, DONE.
- stall_o, combinational:
  - (read_i|write_i) in IDLE.
  - 1 in READ/WRITE.
  - 0 in DONE.
- IDLE:
  - Samples requests; requests are sampled only here.
  - write_i has priority if read_i and write_i are both high.
  - On a request: latch address[ADDR_W+1:2] and data_i; counter=RD_WAIT or WR_WAIT; go to READ or WRITE.
- READ:
  - ce_n=0, oe_n=0, we_n=1, data_oe=0.
  - Counter decrements each cycle.
  - On the edge where counter==0: data_o<=sram_data_i; go to DONE. Strobe lasts RD_WAIT+1 cycles.
- WRITE:
  - ce_n=0, we_n=0, oe_n=1, data_oe=1, sram_data_o=latched data.
  - Lasts WR_WAIT+1 cycles, then DONE.
- DONE:
  - One cycle, stall_o=0; requester advances at the ending edge.
  - After a write: we_n=1 while ce_n=0, addr and data_oe stay asserted (hold time).
  - After a read: ce_n=oe_n=1.
  - Next state always IDLE.
- Latency, request cycle to last stall cycle inclusive: read RD_WAIT+2 stall cycles; write WR_WAIT+2. The DONE cycle follows.
- data_o changes only at read completion and holds through any number of subsequent writes or idle cycles.
- Address/data inputs that change after acceptance are ignored until the next IDLE.
- Never drive data_oe=1 and oe_n=0 in the same cycle. Never assert we_n=0 in the first cycle after a read strobe; the IDLE gap guarantees this.

Optional Feature:
- Macro SRAM_POSTED_WRITE_EN.
- When defined:
  - A write accepted in IDLE gives stall_o=0 in the accept cycle (posted); the controller proceeds through WRITE/DONE without stalling the requester.
  - Any request arriving while the posted write drains sees stall_o=1 until the controller returns to IDLE and accepts it.
  - Reads after a posted write therefore return the new data.
- When undefined: writes stall as described above.

Decomposition:
- Shared package holds:
  - state enum encoding (IDLE=0, READ=1, WRITE=2, DONE=3)
  - default ADDR_W
  - wait-count width constant (4)
- One natural sub-module, sram_strobe_timer: a loadable down-counter with a zero flag, reusable for other wait-state peripherals.
- The FSM and pad muxing stay in sram_ctrl.

Test Plan:
- Reset mid-WRITE (rst_n low in 2nd strobe cycle) -> we_n, ce_n high and data_oe 0 immediately; state IDLE; data_o=0.
- RD_WAIT=1, read_i at address 0x0000_0010, model returns 0xDEADBEEF -> sram_addr_o=4; oe_n low 2 cycles; stall_o high 3 cycles; data_o=0xDEADBEEF from the DONE cycle and held.
- WR_WAIT=0, write 0x12345678 to 0x20 -> we_n low exactly 1 cycle with sram_data_o=0x12345678 and addr=8; data_oe held one more cycle with we_n high; data_o unchanged.
- Read-modify-write sequence: read 0x20 then write merged data 0xAA345678 -> memory model holds 0xAA345678; data_o keeps the pre-write value 0x12345678 through the write.
- read_i and write_i both high -> write performed; no oe_n pulse; data_o unchanged.
- With SRAM_POSTED_WRITE_EN: write then immediate read of the same address -> write accept cycle stall_o=0; read stalls until write DONE passes; data_o returns the written value.
